// File: rtl/ex_stage_pkg.sv
// Shared types and width constants for the execute stage.
package ex_stage_pkg;

  localparam int XLEN           = 32;
  localparam int XLEN_LOG2_DFLT = $clog2(XLEN);

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_XOR    = 5'd2,
    ALU_OR     = 5'd3,
    ALU_AND    = 5'd4,
    ALU_SLL    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_SLT    = 5'd8,
    ALU_SLTU   = 5'd9,
    ALU_PASS_B = 5'd10,
    ALU_MUL    = 5'd11,
    ALU_MULH   = 5'd12,
    ALU_MULHSU = 5'd13,
    ALU_MULHU  = 5'd14,
    ALU_DIV    = 5'd15,
    ALU_DIVU   = 5'd16,
    ALU_REM    = 5'd17,
    ALU_REMU   = 5'd18
  } alu_op_e;

  typedef enum logic [3:0] {
    BR_NONE = 4'd0,
    BR_EQ   = 4'd1,
    BR_NE   = 4'd2,
    BR_LT   = 4'd3,
    BR_GE   = 4'd4,
    BR_LTU  = 4'd5,
    BR_GEU  = 4'd6,
    BR_JAL  = 4'd7,
    BR_JALR = 4'd8
  } br_op_e;

  typedef enum logic [1:0] {
    FWD_REG     = 2'd0,
    FWD_MEM     = 2'd1,
    FWD_WB      = 2'd2,
    FWD_REG_ALT = 2'd3
  } fwd_sel_e;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX inputs and EX/MEM outputs of the execute stage; master = upstream driver.
interface ex_stage_if
  import ex_stage_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN
) ();

  logic                  i_valid;
  alu_op_e               i_alu_op;
  br_op_e                i_br_op;
  logic                  i_src_a_pc;
  logic                  i_src_b_imm;
  logic [DATA_WIDTH-1:0] i_pc;
  logic [DATA_WIDTH-1:0] i_imm;
  logic [DATA_WIDTH-1:0] i_rs1_data;
  logic [DATA_WIDTH-1:0] i_rs2_data;
  fwd_sel_e              i_fwd_a_sel;
  fwd_sel_e              i_fwd_b_sel;
  logic [DATA_WIDTH-1:0] i_fwd_mem_data;
  logic [DATA_WIDTH-1:0] i_fwd_wb_data;
  logic [4:0]            i_rd;
  logic                  i_reg_we;
  logic                  i_mem_we;
  logic                  i_mem_re;

  logic                  o_stall;
  logic                  o_redirect;
  logic [DATA_WIDTH-1:0] o_redirect_pc;
  logic                  o_valid;
  logic [DATA_WIDTH-1:0] o_alu_result;
  logic [DATA_WIDTH-1:0] o_wrdata;
  logic [4:0]            o_rd;
  logic                  o_reg_we;
  logic                  o_mem_we;
  logic                  o_mem_re;

  modport master (
    output i_valid, i_alu_op, i_br_op, i_src_a_pc, i_src_b_imm, i_pc, i_imm,
           i_rs1_data, i_rs2_data, i_fwd_a_sel, i_fwd_b_sel, i_fwd_mem_data,
           i_fwd_wb_data, i_rd, i_reg_we, i_mem_we, i_mem_re,
    input  o_stall, o_redirect, o_redirect_pc, o_valid, o_alu_result, o_wrdata,
           o_rd, o_reg_we, o_mem_we, o_mem_re
  );

  modport slave (
    input  i_valid, i_alu_op, i_br_op, i_src_a_pc, i_src_b_imm, i_pc, i_imm,
           i_rs1_data, i_rs2_data, i_fwd_a_sel, i_fwd_b_sel, i_fwd_mem_data,
           i_fwd_wb_data, i_rd, i_reg_we, i_mem_we, i_mem_re,
    output o_stall, o_redirect, o_redirect_pc, o_valid, o_alu_result, o_wrdata,
           o_rd, o_reg_we, o_mem_we, o_mem_re
  );

endinterface

// File: rtl/ex_stage_divider.sv
// Iterative radix-2 restoring divider: IDLE -> BUSY (one quotient bit per cycle) -> DONE.
module ex_stage_divider
  import ex_stage_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN,
  parameter int XLEN_LOG2  = XLEN_LOG2_DFLT
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  start,
  input  logic                  is_signed,
  input  logic                  rem_sel,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  function automatic logic [DATA_WIDTH-1:0] cond_neg(logic [DATA_WIDTH-1:0] v, logic neg);
    return neg ? -v : v;
  endfunction

  div_state_e            state;
  logic [XLEN_LOG2-1:0]  cnt;
  logic [DATA_WIDTH-1:0] rem_acc;
  logic [DATA_WIDTH-1:0] quo;
  logic [DATA_WIDTH-1:0] divisor;
  logic                  neg_q;
  logic                  neg_r;
  logic                  rem_q;
  logic [DATA_WIDTH:0]   shifted;
  logic [DATA_WIDTH:0]   trial;

  assign shifted = {rem_acc, quo[DATA_WIDTH-1]};
  assign trial   = shifted - {1'b0, divisor};

  // control: state and iteration counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= DIV_IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        DIV_IDLE: if (start) begin
          state <= DIV_BUSY;
          cnt   <= '1;
        end
        DIV_BUSY: begin
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= DIV_DONE;
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end

  // datapath: magnitudes are divided, signs are applied on the way out
  always_ff @(posedge i_clk) begin
    if (state == DIV_IDLE && start) begin
      quo     <= cond_neg(a, is_signed & a[DATA_WIDTH-1]);
      divisor <= cond_neg(b, is_signed & b[DATA_WIDTH-1]);
      rem_acc <= '0;
      neg_q   <= is_signed & (a[DATA_WIDTH-1] ^ b[DATA_WIDTH-1]);
      neg_r   <= is_signed & a[DATA_WIDTH-1];
      rem_q   <= rem_sel;
    end else if (state == DIV_BUSY) begin
      if (trial[DATA_WIDTH]) begin
        rem_acc <= shifted[DATA_WIDTH-1:0];
        quo     <= {quo[DATA_WIDTH-2:0], 1'b0};
      end else begin
        rem_acc <= trial[DATA_WIDTH-1:0];
        quo     <= {quo[DATA_WIDTH-2:0], 1'b1};
      end
    end
  end

  assign busy   = (state == DIV_BUSY);
  assign done   = (state == DIV_DONE);
  assign result = rem_q ? cond_neg(rem_acc, neg_r) : cond_neg(quo, neg_q);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU with single-cycle multiply, branch resolution,
// iterative divider and the EX/MEM pipeline register.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN,
  parameter int XLEN_LOG2  = XLEN_LOG2_DFLT
) (
  input  logic      i_clk,
  input  logic      i_rst,
  ex_stage_if.slave bus
);

  localparam int                    DW       = DATA_WIDTH;
  localparam logic [DW-1:0]         INT_MIN  = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0]         LINK_OFS = DW'(4);

  function automatic logic [DW-1:0] fwd_mux(fwd_sel_e sel, logic [DW-1:0] reg_val,
                                            logic [DW-1:0] mem_val, logic [DW-1:0] wb_val);
    case (sel)
      FWD_MEM: return mem_val;
      FWD_WB:  return wb_val;
      default: return reg_val;
    endcase
  endfunction

  logic signed [DW-1:0]   rs1_fwd, rs2_fwd, op_a, op_b;
  logic [XLEN_LOG2-1:0]   shamt;
  logic signed [DW:0]     mul_a, mul_b;
  logic signed [2*DW-1:0] prod;
  logic [DW-1:0]          alu_res, special_res, div_result, ex_result;
  logic [DW-1:0]          jalr_sum;
  logic                   is_div, div_signed, div_rem, div_zero, div_ovf;
  logic                   div_start, div_busy, div_done, stall, taken;

  assign rs1_fwd = fwd_mux(bus.i_fwd_a_sel, bus.i_rs1_data, bus.i_fwd_mem_data, bus.i_fwd_wb_data);
  assign rs2_fwd = fwd_mux(bus.i_fwd_b_sel, bus.i_rs2_data, bus.i_fwd_mem_data, bus.i_fwd_wb_data);
  assign op_a    = bus.i_src_a_pc  ? bus.i_pc  : rs1_fwd;
  assign op_b    = bus.i_src_b_imm ? bus.i_imm : rs2_fwd;
  assign shamt   = op_b[XLEN_LOG2-1:0];

  assign is_div     = bus.i_alu_op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  assign div_signed = bus.i_alu_op inside {ALU_DIV, ALU_REM};
  assign div_rem    = bus.i_alu_op inside {ALU_REM, ALU_REMU};
  assign div_zero   = (op_b == '0);
  assign div_ovf    = div_signed & (op_a == INT_MIN) & (op_b == '1);
  // Special cases are resolved here in one cycle; only the general case occupies the divider.
  assign div_start  = bus.i_valid & is_div & ~div_zero & ~div_ovf & ~div_busy & ~div_done;
  assign stall      = ~i_rst & (div_start | div_busy);

  ex_stage_divider #(
    .DATA_WIDTH (DW),
    .XLEN_LOG2  (XLEN_LOG2)
  ) u_div (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .start     (div_start),
    .is_signed (div_signed),
    .rem_sel   (div_rem),
    .a         (op_a),
    .b         (op_b),
    .busy      (div_busy),
    .done      (div_done),
    .result    (div_result)
  );

  always_comb begin
    mul_a = {(bus.i_alu_op inside {ALU_MULH, ALU_MULHSU}) & op_a[DW-1], op_a};
    mul_b = {(bus.i_alu_op == ALU_MULH) & op_b[DW-1], op_b};
    prod  = mul_a * mul_b;
  end

  always_comb begin
    if (div_rem) special_res = div_zero ? op_a : '0;
    else         special_res = div_zero ? '1   : INT_MIN;
  end

  always_comb begin
    alu_res = '0;
    unique case (bus.i_alu_op)
      ALU_ADD:    alu_res = op_a + op_b;
      ALU_SUB:    alu_res = op_a - op_b;
      ALU_XOR:    alu_res = op_a ^ op_b;
      ALU_OR:     alu_res = op_a | op_b;
      ALU_AND:    alu_res = op_a & op_b;
      ALU_SLL:    alu_res = op_a << shamt;
      ALU_SRL:    alu_res = $unsigned(op_a) >> shamt;
      ALU_SRA:    alu_res = op_a >>> shamt;
      ALU_SLT:    alu_res = {{(DW-1){1'b0}}, op_a < op_b};
      ALU_SLTU:   alu_res = {{(DW-1){1'b0}}, $unsigned(op_a) < $unsigned(op_b)};
      ALU_PASS_B: alu_res = op_b;
      ALU_MUL:    alu_res = prod[DW-1:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU: alu_res = prod[2*DW-1:DW];
      default:    alu_res = div_done ? div_result : special_res;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    unique case (bus.i_br_op)
      BR_EQ:           taken = (rs1_fwd == rs2_fwd);
      BR_NE:           taken = (rs1_fwd != rs2_fwd);
      BR_LT:           taken = (rs1_fwd <  rs2_fwd);
      BR_GE:           taken = (rs1_fwd >= rs2_fwd);
      BR_LTU:          taken = ($unsigned(rs1_fwd) <  $unsigned(rs2_fwd));
      BR_GEU:          taken = ($unsigned(rs1_fwd) >= $unsigned(rs2_fwd));
      BR_JAL, BR_JALR: taken = 1'b1;
      default:         taken = 1'b0;
    endcase
  end

  assign jalr_sum  = rs1_fwd + bus.i_imm;
  assign ex_result = (bus.i_br_op inside {BR_JAL, BR_JALR}) ? bus.i_pc + LINK_OFS : alu_res;

  assign bus.o_stall       = stall;
  assign bus.o_redirect    = ~i_rst & bus.i_valid & taken;
  assign bus.o_redirect_pc = (bus.i_br_op == BR_JALR) ? {jalr_sum[DW-1:1], 1'b0}
                                                      : bus.i_pc + bus.i_imm;

  logic          vld_p1, reg_we_p1, mem_we_p1, mem_re_p1;
  logic [DW-1:0] result_p1, wrdata_p1;
  logic [4:0]    rd_p1;

  // EX -> MEM boundary; a stalled cycle lands here as a bubble with all strobes low
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_p1    <= 1'b0;
      reg_we_p1 <= 1'b0;
      mem_we_p1 <= 1'b0;
      mem_re_p1 <= 1'b0;
      result_p1 <= '0;
      wrdata_p1 <= '0;
      rd_p1     <= '0;
    end else begin
      vld_p1    <= bus.i_valid & ~stall;
      reg_we_p1 <= bus.i_reg_we & bus.i_valid & ~stall;
      mem_we_p1 <= bus.i_mem_we & bus.i_valid & ~stall;
      mem_re_p1 <= bus.i_mem_re & bus.i_valid & ~stall;
      result_p1 <= ex_result;
      wrdata_p1 <= rs2_fwd;
      rd_p1     <= bus.i_rd;
    end
  end

  assign bus.o_valid      = vld_p1;
  assign bus.o_reg_we     = reg_we_p1;
  assign bus.o_mem_we     = mem_we_p1;
  assign bus.o_mem_re     = mem_re_p1;
  assign bus.o_alu_result = result_p1;
  assign bus.o_wrdata     = wrdata_p1;
  assign bus.o_rd         = rd_p1;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed cases plus random instructions against a behavioural model.
module tb_ex_stage;
  import ex_stage_pkg::*;

  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ex_stage_if #(.DATA_WIDTH(DW)) bus ();

  ex_stage #(.DATA_WIDTH(DW), .XLEN_LOG2(5)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  typedef struct {
    logic        valid;
    alu_op_e     op;
    br_op_e      br;
    logic        a_pc, b_imm;
    logic [31:0] pc, imm, rs1, rs2, fmem, fwb;
    fwd_sel_e    fa, fb;
    logic [4:0]  rd;
    logic        rwe, mwe, mre;
  } instr_t;

  function automatic instr_t nop();
    instr_t t;
    t.valid = 0; t.op = ALU_ADD; t.br = BR_NONE; t.a_pc = 0; t.b_imm = 0;
    t.pc = 0; t.imm = 0; t.rs1 = 0; t.rs2 = 0; t.fmem = 0; t.fwb = 0;
    t.fa = FWD_REG; t.fb = FWD_REG; t.rd = 0; t.rwe = 0; t.mwe = 0; t.mre = 0;
    return t;
  endfunction

  task automatic drive(instr_t t);
    bus.i_valid = t.valid;       bus.i_alu_op = t.op;        bus.i_br_op = t.br;
    bus.i_src_a_pc = t.a_pc;     bus.i_src_b_imm = t.b_imm;  bus.i_pc = t.pc;
    bus.i_imm = t.imm;           bus.i_rs1_data = t.rs1;     bus.i_rs2_data = t.rs2;
    bus.i_fwd_a_sel = t.fa;      bus.i_fwd_b_sel = t.fb;     bus.i_fwd_mem_data = t.fmem;
    bus.i_fwd_wb_data = t.fwb;   bus.i_rd = t.rd;            bus.i_reg_we = t.rwe;
    bus.i_mem_we = t.mwe;        bus.i_mem_re = t.mre;
  endtask

  // ---------------- behavioural reference ----------------
  function automatic logic [31:0] fwd(fwd_sel_e s, logic [31:0] r, logic [31:0] m, logic [31:0] w);
    if (s == FWD_MEM) return m;
    if (s == FWD_WB)  return w;
    return r;
  endfunction

  function automatic logic [31:0] model_res(alu_op_e op, br_op_e br, logic [31:0] a,
                                            logic [31:0] b, logic [31:0] pc);
    longint sa, sb;
    longint unsigned ua, ub;
    int ia, ib;
    logic [4:0] sh;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = {32'b0, a};           ub = {32'b0, b};
    ia = a;                    ib = b;
    sh = b[4:0];
    if (br == BR_JAL || br == BR_JALR) return pc + 32'd4;
    case (op)
      ALU_ADD:    return a + b;
      ALU_SUB:    return a - b;
      ALU_XOR:    return a ^ b;
      ALU_OR:     return a | b;
      ALU_AND:    return a & b;
      ALU_SLL:    return a << sh;
      ALU_SRL:    return a >> sh;
      ALU_SRA:    return 32'(ia >>> sh);
      ALU_SLT:    return (sa < sb) ? 32'd1 : 32'd0;
      ALU_SLTU:   return (ua < ub) ? 32'd1 : 32'd0;
      ALU_PASS_B: return b;
      ALU_MUL:    return 32'(sa * sb);
      ALU_MULH:   return 32'((sa * sb) >> 32);
      ALU_MULHSU: return 32'((sa * longint'(ub)) >> 32);
      ALU_MULHU:  return 32'((ua * ub) >> 32);
      ALU_DIV:    return (b == 0) ? 32'hFFFF_FFFF :
                         (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 : 32'(ia / ib);
      ALU_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      ALU_REM:    return (b == 0) ? a :
                         (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(ia % ib);
      ALU_REMU:   return (b == 0) ? a : a % b;
      default:    return 32'd0;
    endcase
  endfunction

  function automatic logic model_taken(br_op_e br, logic [31:0] x, logic [31:0] y);
    int sx, sy;
    sx = x; sy = y;
    case (br)
      BR_EQ:           return x == y;
      BR_NE:           return x != y;
      BR_LT:           return sx < sy;
      BR_GE:           return sx >= sy;
      BR_LTU:          return x < y;
      BR_GEU:          return x >= y;
      BR_JAL, BR_JALR: return 1'b1;
      default:         return 1'b0;
    endcase
  endfunction

  logic        model_ok = 1'b0;
  int          occ = 0;
  logic        e_vld, e_rwe, e_mwe, e_mre, e_data;
  logic [31:0] e_res, e_wd;
  logic [4:0]  e_rd;

  // One compare point per cycle, mid-cycle, while inputs are stable.
  always @(negedge clk) begin
    logic [31:0] r1, r2, a, b, tgt;
    logic isdiv, spec, sgn, stall_e, redir_e;
    r1 = fwd(bus.i_fwd_a_sel, bus.i_rs1_data, bus.i_fwd_mem_data, bus.i_fwd_wb_data);
    r2 = fwd(bus.i_fwd_b_sel, bus.i_rs2_data, bus.i_fwd_mem_data, bus.i_fwd_wb_data);
    a  = bus.i_src_a_pc  ? bus.i_pc  : r1;
    b  = bus.i_src_b_imm ? bus.i_imm : r2;
    isdiv = bus.i_alu_op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    sgn   = bus.i_alu_op inside {ALU_DIV, ALU_REM};
    spec  = (b == 0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    stall_e = !rst && bus.i_valid && isdiv && !spec && (occ < 33);
    redir_e = !rst && bus.i_valid && model_taken(bus.i_br_op, r1, r2);
    tgt = (bus.i_br_op == BR_JALR) ? ((r1 + bus.i_imm) & 32'hFFFF_FFFE) : bus.i_pc + bus.i_imm;

    chk("stall", {31'b0, bus.o_stall}, {31'b0, stall_e});
    chk("redirect", {31'b0, bus.o_redirect}, {31'b0, redir_e});
    if (redir_e) chk("redirect_pc", bus.o_redirect_pc, tgt);
    if (model_ok) begin
      chk("o_valid", {31'b0, bus.o_valid}, {31'b0, e_vld});
      chk("o_we", {29'b0, bus.o_reg_we, bus.o_mem_we, bus.o_mem_re}, {29'b0, e_rwe, e_mwe, e_mre});
      if (e_data) begin
        chk("o_alu_result", bus.o_alu_result, e_res);
        chk("o_wrdata", bus.o_wrdata, e_wd);
        chk("o_rd", {27'b0, bus.o_rd}, {27'b0, e_rd});
      end
    end

    if (rst) begin
      model_ok = 1'b1; occ = 0;
      e_vld = 0; e_rwe = 0; e_mwe = 0; e_mre = 0; e_data = 1;
      e_res = 0; e_wd = 0; e_rd = 0;
    end else begin
      e_vld  = bus.i_valid && !stall_e;
      e_rwe  = bus.i_reg_we && e_vld;
      e_mwe  = bus.i_mem_we && e_vld;
      e_mre  = bus.i_mem_re && e_vld;
      e_data = e_vld;
      e_res  = model_res(bus.i_alu_op, bus.i_br_op, a, b, bus.i_pc);
      e_wd   = r2;
      e_rd   = bus.i_rd;
      occ    = stall_e ? occ + 1 : 0;
    end
  end

  // Hold the current instruction until EX accepts it; return the registered result.
  task automatic run(output logic [31:0] res, output int stalls);
    stalls = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!bus.o_stall) break;
      stalls++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    res = bus.o_alu_result;
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom();
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    instr_t t;
    logic [31:0] res;
    int st;

    drive(nop());
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", {31'b0, bus.o_valid}, 32'd0);
    chk("rst_result", bus.o_alu_result, 32'd0);
    chk("rst_stall", {31'b0, bus.o_stall}, 32'd0);
    @(posedge clk); #1;

    // ADD with rs2 forwarded from MEM
    t = nop(); t.valid = 1; t.rs1 = 5; t.rs2 = 99; t.fb = FWD_MEM; t.fmem = 7; t.rd = 3; t.rwe = 1;
    drive(t); run(res, st);
    chk("add_result", res, 32'd12);
    chk("add_stall", st, 0);
    chk("add_valid", {31'b0, bus.o_valid}, 32'd1);

    // BLT taken, BLTU not taken
    t = nop(); t.valid = 1; t.br = BR_LT; t.rs1 = 32'hFFFF_FFFF; t.rs2 = 1; t.pc = 32'h100; t.imm = 32'h20;
    drive(t); @(negedge clk);
    chk("blt_redirect", {31'b0, bus.o_redirect}, 32'd1);
    chk("blt_target", bus.o_redirect_pc, 32'h120);
    @(posedge clk); #1;
    t.br = BR_LTU; drive(t); @(negedge clk);
    chk("bltu_redirect", {31'b0, bus.o_redirect}, 32'd0);
    @(posedge clk); #1;

    // JALR target and link value
    t = nop(); t.valid = 1; t.br = BR_JALR; t.rs1 = 32'h203; t.imm = 4; t.b_imm = 1;
    t.pc = 32'h40; t.rd = 1; t.rwe = 1;
    drive(t); @(negedge clk);
    chk("jalr_target", bus.o_redirect_pc, 32'h206);
    @(posedge clk); #1;
    chk("jalr_link", bus.o_alu_result, 32'h44);

    // Iterative divide
    t = nop(); t.valid = 1; t.op = ALU_DIV; t.rs1 = -32'sd7; t.rs2 = 2; t.rd = 4; t.rwe = 1;
    drive(t); run(res, st);
    chk("div_stall_cycles", st, 33);
    chk("div_result", res, -32'sd3);
    t.op = ALU_REM; drive(t); run(res, st);
    chk("rem_result", res, -32'sd1);

    // Special cases, no stall
    t.op = ALU_DIVU; t.rs1 = 5; t.rs2 = 0; drive(t); run(res, st);
    chk("divu_zero_result", res, 32'hFFFF_FFFF);
    chk("divu_zero_stall", st, 0);
    t.op = ALU_DIV; t.rs1 = 32'h8000_0000; t.rs2 = 32'hFFFF_FFFF; drive(t); run(res, st);
    chk("div_ovf_result", res, 32'h8000_0000);
    chk("div_ovf_stall", st, 0);
    t.op = ALU_REM; drive(t); run(res, st);
    chk("rem_ovf_result", res, 32'd0);

    // Reset in the middle of a division
    t.op = ALU_DIVU; t.rs1 = 9; t.rs2 = 2; drive(t);
    repeat (11) begin @(posedge clk); #1; end
    rst = 1'b1; drive(nop());
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy_stall", {31'b0, bus.o_stall}, 32'd0);
    chk("rst_busy_valid", {31'b0, bus.o_valid}, 32'd0);
    @(posedge clk); #1;
    t.rs1 = 100; t.rs2 = 7; drive(t); run(res, st);
    chk("divu_after_rst", res, 32'd14);
    chk("divu_after_rst_stall", st, 33);

    // Random instruction stream
    for (int n = 0; n < 300; n++) begin
      t = nop();
      t.valid = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 99) < 12) begin
        t.op = alu_op_e'($urandom_range(15, 18));
        t.br = BR_NONE;
      end else begin
        t.op = alu_op_e'($urandom_range(0, 14));
        t.br = ($urandom_range(0, 1) != 0) ? br_op_e'($urandom_range(1, 8)) : BR_NONE;
      end
      t.a_pc = ($urandom_range(0, 3) == 0); t.b_imm = ($urandom_range(0, 2) == 0);
      t.pc = $urandom() & 32'hFFFF_FFFC; t.imm = rnd_val();
      t.rs1 = rnd_val(); t.rs2 = rnd_val(); t.fmem = rnd_val(); t.fwb = rnd_val();
      t.fa = fwd_sel_e'($urandom_range(0, 3)); t.fb = fwd_sel_e'($urandom_range(0, 3));
      t.rd = 5'($urandom_range(0, 31));
      t.rwe = 1'($urandom_range(0, 1)); t.mwe = 1'($urandom_range(0, 1)); t.mre = 1'($urandom_range(0, 1));
      drive(t); run(res, st);
    end

    drive(nop());
    repeat (2) begin @(posedge clk); #1; end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
